// File: rtl/hs_data_responder_pkg.sv
// Shared definitions for the bundled-data handshake responder and other
// single-clock CDC endpoints built from the same pieces.
package hs_data_responder_pkg;

  // Handshake FSM states: IDLE waits for a request, WAIT_LO holds ack high
  // until the initiator withdraws its request.
  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_e;

  // Default depth of a level synchronizer chain (legal range 2..4).
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned MIN_SYNC_STAGES     = 2;
  localparam int unsigned MAX_SYNC_STAGES     = 4;

  // Rising-edge detect between the current and previous sample of a level.
  function automatic logic is_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/hs_data_responder_level_sync.sv
// Parameterized N-flop single-bit level synchronizer with a synchronous
// active-high reset. o_Q is the synchronized level; o_QNext is the value
// o_Q will take on the next edge (the penultimate stage), which lets a
// consumer tell a one-cycle dip on o_Q apart from a settled level.
module level_sync #(
  parameter int unsigned N = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_D,
  output logic o_Q,
  output logic o_QNext
);

  logic [N-1:0] r_chain;

  // Shift the asynchronous level through the synchronizer flops.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[N-2:0], i_D};
    end
  end

  assign o_Q     = r_chain[N-1];
  assign o_QNext = r_chain[N-2];

endmodule

// File: rtl/hs_data_responder.sv
// Receiving end of a 4-phase req/ack bundled-data handshake. The request is
// synchronized into i_Clk, the word is captured into a one-deep output slot
// and acknowledged; ack is withheld while the slot is still occupied.
module hs_data_responder
  import hs_data_responder_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_aReq,
  input  logic [DATA_W-1:0] i_aData,
  output logic              o_Ack,
  output logic [DATA_W-1:0] o_Data,
  input  logic              i_Ready,
  output logic              o_Valid,
  output logic              o_Busy,
  output logic [CNT_W-1:0]  o_XferCnt,
  output logic              o_ProtoErr
);

  state_e             r_state;
  logic               r_ack;
  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_req_d;
  logic               r_busy;

  logic               w_req_s;
  logic               w_req_next;
  logic               w_slot_free;
  logic               w_capture;
  logic               w_release;
  logic               w_rise;
  state_e             w_state_nxt;

  // Only the request crosses domains; the data is qualified by it.
  level_sync #(
    .N (SYNC_STAGES)
  ) u_req_sync (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_D     (i_aReq),
    .o_Q     (w_req_s),
    .o_QNext (w_req_next)
  );

  assign w_slot_free = ~r_valid | i_Ready;

  // Decide capture, release and protocol-error events for this cycle.
  // Release needs the request low at both the output and the penultimate
  // synchronizer stage, so a request that drops for a single cycle and
  // comes straight back is seen as a rising edge while still in WAIT_LO
  // (flagged as an error) rather than as a fresh handshake that would
  // capture the same word twice. A settled low still releases on the same
  // edge as a plain level check would.
  always_comb begin
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_rise      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req_s & w_slot_free) begin
          w_capture   = 1'b1;
          w_state_nxt = WAIT_LO;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_LO: begin
        w_rise = is_rise(w_req_s, r_req_d);
        if (~w_req_s & ~w_req_next) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_LO;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake FSM with output slot, transfer counter and sticky error flag.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_req_d <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req_d <= w_req_s;
      // Busy mirrors (state != IDLE) | req_s as they will stand after this edge.
      r_busy  <= (w_state_nxt == WAIT_LO) | w_req_next;

      if (w_capture) begin
        r_data  <= i_aData;
        r_valid <= 1'b1;
        r_ack   <= 1'b1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (r_valid & i_Ready) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      if (w_release) begin
        r_ack <= 1'b0;
      end else begin
        r_ack <= r_ack | w_capture;
      end

      if (w_rise) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign o_Ack      = r_ack;
  assign o_Data     = r_data;
  assign o_Valid    = r_valid;
  assign o_Busy     = r_busy;
  assign o_XferCnt  = r_cnt;
  assign o_ProtoErr = r_err;

endmodule
